pipe_hazard_sequencer: RTL and testbench

PIPE_HAZARD_SEQUENCER -- requirements
Module: pipe_hazard_sequencer

---
 rtl/pipe_hazard_sequencer.sv | 137 +++++++++++++
 tb/tb_pipe_hazard_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_sequencer.sv
// Pipeline hazard sequencer: turns redirect, load-use and mult/div events into
// PC/IF-ID/ID-EX write enables, flushes and an EX/MEM bubble, with a stall counter.
module pipe_hazard_sequencer #(
    parameter int SQUASH_LEN = 2,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirect_req,
    input  logic             load_use,
    input  logic             md_start,
    input  logic             md_done,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_bubble,
    output logic             pc_redirect,
    output logic             busy,
    output logic             md_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       dbg_state
);

    localparam int SQ_W = (SQUASH_LEN > 0) ? $clog2(SQUASH_LEN + 1) : 1;
    localparam int TO_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_LEN);
    localparam logic [SQ_W-1:0] SQ_ONE  = SQ_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SQUASH  = 2'd1,
        ST_MD_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [SQ_W-1:0]   r_sq_cnt;
    logic [SQ_W-1:0]   w_sq_cnt_nxt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [TO_W-1:0]   w_to_cnt_nxt;
    logic              w_set_err;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              r_timeout_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_sq_cnt      <= '0;
            r_to_cnt      <= '0;
            r_stall_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_sq_cnt <= w_sq_cnt_nxt;
            r_to_cnt <= w_to_cnt_nxt;
            if (!pc_we && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_set_err) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // Outputs are Mealy; while reset is held they stay at the run defaults
    // even if request inputs are toggling.
    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idex_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        pc_redirect  = 1'b0;
        w_next_state = r_state;
        w_sq_cnt_nxt = r_sq_cnt;
        w_to_cnt_nxt = r_to_cnt;
        w_set_err    = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_RUN: begin
                    if (redirect_req) begin
                        pc_redirect  = 1'b1;
                        ifid_flush   = 1'b1;
                        idex_flush   = 1'b1;
                        w_next_state = ST_SQUASH;
                        w_sq_cnt_nxt = SQ_LOAD;
                    end else if (md_start) begin
                        w_next_state = ST_MD_WAIT;
                        w_to_cnt_nxt = '0;
                    end else if (load_use) begin
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                ST_SQUASH: begin
                    exmem_bubble = 1'b1;
                    w_sq_cnt_nxt = r_sq_cnt - SQ_ONE;
                    if (r_sq_cnt <= SQ_ONE) begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_MD_WAIT: begin
                    if (md_done) begin
                        w_next_state = ST_RUN;
                    end else begin
                        pc_we        = 1'b0;
                        ifid_we      = 1'b0;
                        idex_we      = 1'b0;
                        exmem_bubble = 1'b1;
                        // Last permitted wait cycle: give up and flag it.
                        if (r_to_cnt == TO_LAST) begin
                            w_set_err    = 1'b1;
                            w_next_state = ST_RUN;
                        end else begin
                            w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                        end
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    assign busy           = (r_state != ST_RUN);
    assign md_timeout_err = r_timeout_err;
    assign stall_cycles   = r_stall_cnt;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed bench for pipe_hazard_sequencer: a cycle-level behavioural model checked
// every falling edge, plus hand-computed literal expectations per scenario.
module tb_pipe_hazard_sequencer;

    localparam int SQUASH_LEN = 2;
    localparam int MD_TIMEOUT = 64;
    localparam int CNT_W      = 6;
    localparam int STALL_MAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             redirect_req;
    logic             load_use;
    logic             md_start;
    logic             md_done;
    logic             pc_we;
    logic             ifid_we;
    logic             idex_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_bubble;
    logic             pc_redirect;
    logic             busy;
    logic             md_timeout_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string name;
        int    id;
        int    val;
    } lit_t;
    lit_t lit_q[$];

    pipe_hazard_sequencer #(
        .SQUASH_LEN(SQUASH_LEN),
        .MD_TIMEOUT(MD_TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_req  (redirect_req),
        .load_use      (load_use),
        .md_start      (md_start),
        .md_done       (md_done),
        .pc_we         (pc_we),
        .ifid_we       (ifid_we),
        .idex_we       (idex_we),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .exmem_bubble  (exmem_bubble),
        .pc_redirect   (pc_redirect),
        .busy          (busy),
        .md_timeout_err(md_timeout_err),
        .stall_cycles  (stall_cycles),
        .dbg_state     (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_PC_WE = 0, S_IFID_WE = 1, S_IDEX_WE = 2, S_IFID_FL = 3, S_IDEX_FL = 4,
                   S_BUBBLE = 5, S_REDIR = 6, S_BUSY = 7, S_ERR = 8, S_STALL = 9;

    function automatic int sig(input int id);
        case (id)
            S_PC_WE:   return int'(pc_we);
            S_IFID_WE: return int'(ifid_we);
            S_IDEX_WE: return int'(idex_we);
            S_IFID_FL: return int'(ifid_flush);
            S_IDEX_FL: return int'(idex_flush);
            S_BUBBLE:  return int'(exmem_bubble);
            S_REDIR:   return int'(pc_redirect);
            S_BUSY:    return int'(busy);
            S_ERR:     return int'(md_timeout_err);
            S_STALL:   return int'(stall_cycles);
            default:   return -1;
        endcase
    endfunction

    // Model state: bubble cycles still owed, whether a mult/div wait is open and
    // how many wait cycles it has used, the sticky error and the stall tally.
    int m_sq_left = 0;
    bit m_in_md   = 1'b0;
    int m_md_used = 0;
    bit m_err     = 1'b0;
    int m_stall   = 0;

    // Single compare process: literal expectations queued this cycle, then the model.
    always @(negedge clk) begin
        lit_t l;
        bit   e_pc, e_ifid, e_idex, e_ifl, e_ifl2, e_bub, e_red, e_busy, set_err;
        logic [7:0] e_vec, a_vec;

        while (lit_q.size() > 0) begin
            l = lit_q.pop_front();
            n_checks++;
            if (sig(l.id) != l.val) begin
                n_errors++;
                $display("FAIL lit_%s got=%0d exp=%0d t=%0t", l.name, sig(l.id), l.val, $time);
            end
        end

        e_pc = 1; e_ifid = 1; e_idex = 1; e_ifl = 0; e_ifl2 = 0; e_bub = 0; e_red = 0;
        set_err = 0;
        if (!rst_n) begin
            m_sq_left = 0; m_in_md = 0; m_md_used = 0; m_err = 0; m_stall = 0;
        end
        e_busy = (m_sq_left > 0) || m_in_md;
        if (rst_n) begin
            if (m_sq_left > 0) begin
                e_bub = 1;
                m_sq_left--;
            end else if (m_in_md) begin
                if (md_done) begin
                    m_in_md = 0;
                end else begin
                    e_pc = 0; e_ifid = 0; e_idex = 0; e_bub = 1;
                    m_md_used++;
                    if (m_md_used == MD_TIMEOUT) begin
                        set_err = 1;
                        m_in_md = 0;
                    end
                end
            end else if (redirect_req) begin
                e_red = 1; e_ifl = 1; e_ifl2 = 1;
                m_sq_left = SQUASH_LEN;
            end else if (md_start) begin
                m_in_md   = 1;
                m_md_used = 0;
            end else if (load_use) begin
                e_pc = 0; e_ifid = 0; e_ifl2 = 1;
            end
        end

        e_vec = {e_pc, e_ifid, e_idex, e_ifl, e_ifl2, e_bub, e_red, e_busy};
        a_vec = {pc_we, ifid_we, idex_we, ifid_flush, idex_flush, exmem_bubble, pc_redirect, busy};
        n_checks++;
        if (a_vec !== e_vec) begin
            n_errors++;
            $display("FAIL outputs got=%b exp=%b (pc,ifid,idex,iffl,idfl,bub,redir,busy) t=%0t",
                     a_vec, e_vec, $time);
        end
        n_checks++;
        if (int'(stall_cycles) != m_stall) begin
            n_errors++;
            $display("FAIL stall_cycles got=%0d exp=%0d t=%0t", stall_cycles, m_stall, $time);
        end
        n_checks++;
        if (md_timeout_err !== m_err) begin
            n_errors++;
            $display("FAIL md_timeout_err got=%0b exp=%0b t=%0t", md_timeout_err, m_err, $time);
        end

        if (rst_n && !e_pc && m_stall < STALL_MAX) m_stall++;
        if (set_err) m_err = 1;
    end

    // Driver tasks
    task automatic apply(input bit r, input bit l, input bit s, input bit d);
        redirect_req = r;
        load_use     = l;
        md_start     = s;
        md_done      = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input string name, input int id, input int val);
        lit_t l;
        l.name = name;
        l.id   = id;
        l.val  = val;
        lit_q.push_back(l);
    endtask

    initial begin
        rst_n = 1'b0;
        apply(0, 0, 0, 0);
        expect_sig("reset_busy", S_BUSY, 0);
        expect_sig("reset_pc_we", S_PC_WE, 1);
        expect_sig("reset_stall", S_STALL, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Scenario 1: single-cycle redirect
        apply(1, 0, 0, 0);
        expect_sig("s1_redirect", S_REDIR, 1);
        expect_sig("s1_ifid_flush", S_IFID_FL, 1);
        expect_sig("s1_idex_flush", S_IDEX_FL, 1);
        expect_sig("s1_pc_we", S_PC_WE, 1);
        tick();
        apply(0, 0, 0, 0);
        expect_sig("s1_t1_bubble", S_BUBBLE, 1);
        expect_sig("s1_t1_redirect", S_REDIR, 0);
        tick();
        expect_sig("s1_t2_bubble", S_BUBBLE, 1);
        tick();
        expect_sig("s1_t3_busy", S_BUSY, 0);
        expect_sig("s1_t3_bubble", S_BUBBLE, 0);
        tick();

        // Scenario 2: redirect held four cycles
        apply(1, 0, 0, 0);
        expect_sig("s2_t0_redirect", S_REDIR, 1);
        tick();
        expect_sig("s2_t1_redirect", S_REDIR, 0);
        tick();
        expect_sig("s2_t2_redirect", S_REDIR, 0);
        tick();
        expect_sig("s2_t3_redirect", S_REDIR, 1);
        tick();
        apply(0, 0, 0, 0);
        tick();
        tick();

        // Scenario 3: mult/div completing after four wait cycles
        apply(0, 0, 1, 0);
        expect_sig("s3_start_pc_we", S_PC_WE, 1);
        tick();
        apply(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            expect_sig("s3_wait_pc_we", S_PC_WE, 0);
            tick();
        end
        apply(0, 0, 0, 1);
        expect_sig("s3_done_pc_we", S_PC_WE, 1);
        expect_sig("s3_stall", S_STALL, 4);
        tick();
        apply(0, 0, 0, 0);
        expect_sig("s3_after_busy", S_BUSY, 0);
        tick();

        // Load-use stall: one cycle only
        apply(0, 1, 0, 0);
        expect_sig("lu_pc_we", S_PC_WE, 0);
        expect_sig("lu_ifid_we", S_IFID_WE, 0);
        expect_sig("lu_idex_we", S_IDEX_WE, 1);
        expect_sig("lu_idex_flush", S_IDEX_FL, 1);
        tick();
        apply(0, 0, 0, 0);
        expect_sig("lu_stall", S_STALL, 5);
        expect_sig("lu_after_pc_we", S_PC_WE, 1);
        tick();

        // Scenario 5: all requests together, redirect wins
        apply(1, 1, 1, 0);
        expect_sig("s5_redirect", S_REDIR, 1);
        expect_sig("s5_pc_we", S_PC_WE, 1);
        expect_sig("s5_ifid_we", S_IFID_WE, 1);
        tick();
        apply(0, 0, 0, 0);
        expect_sig("s5_t1_pc_we", S_PC_WE, 1);
        expect_sig("s5_t1_bubble", S_BUBBLE, 1);
        tick();
        tick();
        expect_sig("s5_t3_busy", S_BUSY, 0);
        expect_sig("s5_stall", S_STALL, 5);
        tick();

        // md_done on the final allowed wait cycle beats the timeout
        apply(0, 0, 1, 0);
        tick();
        apply(0, 0, 0, 0);
        repeat (63) tick();
        apply(0, 0, 0, 1);
        expect_sig("coin_pc_we", S_PC_WE, 1);
        expect_sig("coin_err", S_ERR, 0);
        tick();
        apply(0, 0, 0, 0);
        expect_sig("coin_after_err", S_ERR, 0);
        expect_sig("coin_busy", S_BUSY, 0);
        expect_sig("stall_saturated", S_STALL, STALL_MAX);
        tick();

        // Scenario 4: timeout with md_done never arriving
        apply(0, 0, 1, 0);
        tick();
        apply(0, 0, 0, 0);
        repeat (63) tick();
        expect_sig("s4_last_busy", S_BUSY, 1);
        expect_sig("s4_last_err", S_ERR, 0);
        tick();
        expect_sig("s4_err_set", S_ERR, 1);
        expect_sig("s4_busy", S_BUSY, 0);
        apply(0, 0, 0, 1);
        tick();
        apply(0, 0, 0, 0);
        expect_sig("s4_err_sticky", S_ERR, 1);
        expect_sig("s4_stall_sat", S_STALL, STALL_MAX);
        tick();

        // Scenario 6: asynchronous reset in the middle of a mult/div wait
        apply(0, 0, 1, 0);
        tick();
        apply(0, 0, 0, 0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        expect_sig("s6_busy", S_BUSY, 0);
        expect_sig("s6_pc_we", S_PC_WE, 1);
        expect_sig("s6_stall", S_STALL, 0);
        expect_sig("s6_err", S_ERR, 0);
        tick();
        rst_n = 1'b1;
        tick();
        apply(1, 0, 0, 0);
        expect_sig("s6_post_redirect", S_REDIR, 1);
        tick();
        apply(0, 0, 0, 0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
